// File: rtl/div_nr_param_if.sv
// Handshake and data bundle for div_nr_param.
//   master : requester side (drives ctrl_DIV, is_signed, operands; receives results)
//   slave  : divider side (receives start/operands; drives quotient, remainder,
//            exception flag, one-cycle data_resultRDY pulse and busy)
interface div_nr_param_if #(
    parameter int unsigned WIDTH = 32
);
    logic             ctrl_DIV;
    logic             is_signed;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic [WIDTH-1:0] data_remainder;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_DIV, is_signed, data_operandA, data_operandB,
        input  data_result, data_remainder, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_DIV, is_signed, data_operandA, data_operandB,
        output data_result, data_remainder, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/div_nr_param.sv
// Iterative non-restoring divider, one quotient bit per clock.
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      div_nr_param_if slave: ctrl_DIV start pulse (samples operands and
//            mode), is_signed, data_operandA (dividend), data_operandB (divisor),
//            data_result (quotient), data_remainder, data_exception (divide by
//            zero), data_resultRDY (one-cycle result pulse), busy
// Signed operands are divided as magnitudes and the signs applied at the end;
// a start while busy aborts the running operation.
module div_nr_param #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic           clock,
    input  logic           reset_n,
    div_nr_param_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state;
    logic [WIDTH:0]   remReg;     // signed partial remainder, one guard bit
    logic [WIDTH-1:0] quoReg;     // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] divMag;
    logic             quoNeg;
    logic             remNeg;
    logic [CNT_W-1:0] count;

    logic             signedMode_c;
    logic             aNeg_c;
    logic             bNeg_c;
    logic             bZero_c;
    logic [WIDTH-1:0] aMag_c;
    logic [WIDTH-1:0] bMag_c;
    logic [WIDTH:0]   shifted_c;
    logic [WIDTH:0]   divExt_c;
    logic [WIDTH:0]   stepRem_c;
    logic [WIDTH-1:0] stepQuo_c;
    logic [WIDTH-1:0] fixRem_c;
    logic [WIDTH-1:0] quoOut_c;
    logic [WIDTH-1:0] remOut_c;

    // Operand conditioning, one iteration step and the final correction.
    always_comb begin
        signedMode_c = SIGNED_EN ? bus.is_signed : 1'b0;
        aNeg_c       = signedMode_c & bus.data_operandA[WIDTH-1];
        bNeg_c       = signedMode_c & bus.data_operandB[WIDTH-1];
        bZero_c      = (bus.data_operandB == '0);
        aMag_c       = aNeg_c ? (WIDTH'(0) - bus.data_operandA) : bus.data_operandA;
        bMag_c       = bNeg_c ? (WIDTH'(0) - bus.data_operandB) : bus.data_operandB;

        shifted_c    = {remReg[WIDTH-1:0], quoReg[WIDTH-1]};
        divExt_c     = {1'b0, divMag};
        stepRem_c    = remReg[WIDTH] ? (shifted_c + divExt_c) : (shifted_c - divExt_c);
        stepQuo_c    = {quoReg[WIDTH-2:0], ~stepRem_c[WIDTH]};

        // Only the low WIDTH bits survive; a negative R lands in [0, |B|) after +|B|.
        fixRem_c     = remReg[WIDTH] ? (remReg[WIDTH-1:0] + divMag) : remReg[WIDTH-1:0];
        quoOut_c     = quoNeg ? (WIDTH'(0) - quoReg) : quoReg;
        remOut_c     = remNeg ? (WIDTH'(0) - fixRem_c) : fixRem_c;
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            remReg             <= '0;
            quoReg             <= '0;
            divMag             <= '0;
            quoNeg             <= 1'b0;
            remNeg             <= 1'b0;
            count              <= '0;
            bus.data_result    <= '0;
            bus.data_remainder <= '0;
            bus.data_exception <= 1'b0;
            bus.data_resultRDY <= 1'b0;
            bus.busy           <= 1'b0;
        end else begin
            // The pulse for a finishing operation fires even if a new start lands in DONE.
            bus.data_resultRDY <= (state == DONE);

            if (bus.ctrl_DIV) begin
                if (bZero_c) begin
                    bus.data_result    <= '0;
                    bus.data_remainder <= bus.data_operandA;
                    bus.data_exception <= 1'b1;
                    bus.busy           <= 1'b0;
                    state              <= DONE;
                end else begin
                    divMag   <= bMag_c;
                    quoNeg   <= aNeg_c ^ bNeg_c;
                    remNeg   <= aNeg_c;
                    remReg   <= '0;
                    quoReg   <= aMag_c;
                    count    <= '0;
                    bus.busy <= 1'b1;
                    state    <= RUN;
                end
            end else begin
                case (state)
                    IDLE: ;
                    RUN: begin
                        remReg <= stepRem_c;
                        quoReg <= stepQuo_c;
                        count  <= count + CNT_W'(1);
                        if (count == CNT_W'(WIDTH - 1)) begin
                            state <= FIX;
                        end
                    end
                    FIX: begin
                        bus.data_result    <= quoOut_c;
                        bus.data_remainder <= remOut_c;
                        bus.data_exception <= 1'b0;
                        bus.busy           <= 1'b0;
                        state              <= DONE;
                    end
                    DONE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_div_nr_param.sv
// Self-checking bench for div_nr_param: a 32-bit signed-capable instance and an
// 8-bit unsigned-only instance, checked every cycle against a timeline model
// built from plain integer division, plus directed literal cases.
module tb_div_nr_param;
    logic clock = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    div_nr_param_if #(.WIDTH(32)) bus32 ();
    div_nr_param_if #(.WIDTH(8))  bus8 ();

    div_nr_param #(.WIDTH(32), .SIGNED_EN(1'b1)) dut32 (.clock(clock), .reset_n(reset_n), .bus(bus32));
    div_nr_param #(.WIDTH(8),  .SIGNED_EN(1'b0)) dut8  (.clock(clock), .reset_n(reset_n), .bus(bus8));

    int nChecks = 0;
    int nFail   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int wOf(input int d);
        return (d == 0) ? 32 : 8;
    endfunction

    function automatic bit sEnOf(input int d);
        return (d == 0);
    endfunction

    function automatic logic [63:0] resOf(input int d);
        return (d == 0) ? 64'(bus32.data_result) : 64'(bus8.data_result);
    endfunction
    function automatic logic [63:0] remOf(input int d);
        return (d == 0) ? 64'(bus32.data_remainder) : 64'(bus8.data_remainder);
    endfunction
    function automatic logic excOf(input int d);
        return (d == 0) ? bus32.data_exception : bus8.data_exception;
    endfunction
    function automatic logic rdyOf(input int d);
        return (d == 0) ? bus32.data_resultRDY : bus8.data_resultRDY;
    endfunction
    function automatic logic busyOf(input int d);
        return (d == 0) ? bus32.busy : bus8.busy;
    endfunction

    // Reference arithmetic: truncating division on sign-extended 64-bit values.
    function automatic void model(input int w, input bit s, input logic [63:0] ain,
                                  input logic [63:0] bin, output logic [63:0] q,
                                  output logic [63:0] r, output bit ex);
        logic [63:0] mask;
        logic [63:0] a;
        logic [63:0] b;
        longint      sa;
        longint      sb;
        mask = (64'd1 << w) - 64'd1;
        a = ain & mask;
        b = bin & mask;
        if (b == 64'd0) begin
            q = 64'd0; r = a; ex = 1'b1;
        end else if (s) begin
            sa = $signed(a << (64 - w)) >>> (64 - w);
            sb = $signed(b << (64 - w)) >>> (64 - w);
            q = 64'(sa / sb) & mask;
            r = 64'(sa % sb) & mask;
            ex = 1'b0;
        end else begin
            q = a / b; r = a % b; ex = 1'b0;
        end
    endfunction

    task automatic drive(input int d, input bit c, input logic [63:0] a,
                         input logic [63:0] b, input bit s);
        if (d == 0) begin
            bus32.ctrl_DIV = c; bus32.is_signed = s;
            bus32.data_operandA = a[31:0]; bus32.data_operandB = b[31:0];
        end else begin
            bus8.ctrl_DIV = c; bus8.is_signed = s;
            bus8.data_operandA = a[7:0]; bus8.data_operandB = b[7:0];
        end
    endtask

    // Pulse ctrl_DIV for one edge; operands are scrambled afterwards.
    task automatic startOp(input int d, input logic [63:0] a, input logic [63:0] b, input bit s);
        drive(d, 1'b1, a, b, s);
        @(posedge clock); #1;
        drive(d, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
    endtask

    // Called right after startOp; counts edges after the sampling edge until RDY.
    task automatic waitRdy(input int d, input int maxN, output int n, output int busyCnt);
        n = 0;
        busyCnt = int'(busyOf(d));
        while (n < maxN) begin
            @(posedge clock); #1;
            n++;
            if (rdyOf(d)) return;
            busyCnt += int'(busyOf(d));
        end
        check($sformatf("d%0d.rdyTimeout", d), 64'(rdyOf(d)), 64'd1);
    endtask

    task automatic directed(input string nm, input int d, input logic [63:0] a,
                            input logic [63:0] b, input bit s, input int expN,
                            input logic [63:0] eq, input logic [63:0] er,
                            input bit ee, input int expBusy);
        int n;
        int bc;
        startOp(d, a, b, s);
        waitRdy(d, 80, n, bc);
        check({nm, ".latency"}, 64'(n), 64'(expN));
        check({nm, ".busyCycles"}, 64'(bc), 64'(expBusy));
        check({nm, ".result"}, resOf(d), eq);
        check({nm, ".remainder"}, remOf(d), er);
        check({nm, ".exception"}, 64'(excOf(d)), 64'(ee));
    endtask

    function automatic logic [63:0] pick(input int w);
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return 64'd1;
            2: return '1;
            3: return 64'd1 << (w - 1);
            4: return 64'($urandom_range(0, 15));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Timeline model: every start predicts one write edge and one RDY edge;
    // a later start before the RDY edge cancels it.
    int          edgeCnt = 0;
    bit          pv[2];
    int          pdue[2];
    logic [63:0] pq[2];
    logic [63:0] pr[2];
    bit          pe[2];
    logic [63:0] hq[2];
    logic [63:0] hr[2];
    bit          he[2];
    int          curStart[2];
    bit          curNZ[2];
    bit          snapC[2];
    bit          snapS[2];
    logic [63:0] snapA[2];
    logic [63:0] snapB[2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            pv[d] = 0; pdue[d] = 0; pq[d] = 0; pr[d] = 0; pe[d] = 0;
            hq[d] = 0; hr[d] = 0; he[d] = 0; curStart[d] = 0; curNZ[d] = 0;
            snapC[d] = 0; snapS[d] = 0; snapA[d] = 0; snapB[d] = 0;
        end
        forever begin
            @(negedge clock);
            for (int d = 0; d < 2; d++) begin
                string tag;
                bit expRdy;
                bit expBusy;
                int w;
                w = wOf(d);
                tag = $sformatf("d%0d.cyc", d);
                expRdy = 1'b0;
                if (!reset_n) begin
                    pv[d] = 0; hq[d] = 0; hr[d] = 0; he[d] = 0; curNZ[d] = 0;
                    expBusy = 1'b0;
                end else begin
                    if (pv[d] && pdue[d] == edgeCnt + 1) begin
                        expRdy = 1'b1;
                        pv[d] = 0;
                    end
                    if (snapC[d]) begin
                        model(w, snapS[d] & sEnOf(d), snapA[d], snapB[d], pq[d], pr[d], pe[d]);
                        pv[d] = 1;
                        pdue[d] = edgeCnt + 1 + (pe[d] ? 1 : w + 2);
                        curStart[d] = edgeCnt + 1;
                        curNZ[d] = !pe[d];
                    end
                    if (pv[d] && pdue[d] - 1 == edgeCnt + 1) begin
                        hq[d] = pq[d]; hr[d] = pr[d]; he[d] = pe[d];
                    end
                    expBusy = curNZ[d] && (edgeCnt + 1 - curStart[d] <= w);
                end
                check({tag, ".rdy"}, 64'(rdyOf(d)), 64'(expRdy));
                check({tag, ".busy"}, 64'(busyOf(d)), 64'(expBusy));
                check({tag, ".result"}, resOf(d), hq[d]);
                check({tag, ".remainder"}, remOf(d), hr[d]);
                check({tag, ".exception"}, 64'(excOf(d)), 64'(he[d]));
            end
            if (reset_n) edgeCnt++;
            snapC[0] = reset_n && bus32.ctrl_DIV;
            snapS[0] = bus32.is_signed;
            snapA[0] = 64'(bus32.data_operandA);
            snapB[0] = 64'(bus32.data_operandB);
            snapC[1] = reset_n && bus8.ctrl_DIV;
            snapS[1] = bus8.is_signed;
            snapA[1] = 64'(bus8.data_operandA);
            snapB[1] = 64'(bus8.data_operandB);
        end
    end

    initial begin
        drive(0, 1'b0, 64'd0, 64'd0, 1'b0);
        drive(1, 1'b0, 64'd0, 64'd0, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        check("reset.result", resOf(0), 64'd0);
        check("reset.busy", 64'(busyOf(0)), 64'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        directed("u100_7", 0, 64'd100, 64'd7, 1'b0, 34, 64'd14, 64'd2, 1'b0, 33);
        directed("sM7_2", 0, 64'hFFFFFFF9, 64'd2, 1'b1, 34, 64'hFFFFFFFD, 64'hFFFFFFFF, 1'b0, 33);
        directed("s7_M2", 0, 64'd7, 64'hFFFFFFFE, 1'b1, 34, 64'hFFFFFFFD, 64'd1, 1'b0, 33);
        directed("sOvf", 0, 64'h80000000, 64'hFFFFFFFF, 1'b1, 34, 64'h80000000, 64'd0, 1'b0, 33);
        directed("uOvf", 0, 64'h80000000, 64'hFFFFFFFF, 1'b0, 34, 64'd0, 64'h80000000, 1'b0, 33);
        directed("div0", 0, 64'h1234, 64'd0, 1'b1, 1, 64'd0, 64'h1234, 1'b1, 0);
        directed("after0", 0, 64'd9, 64'd3, 1'b0, 34, 64'd3, 64'd0, 1'b0, 33);

        startOp(0, 64'd1000, 64'd10, 1'b0);
        repeat (9) begin @(posedge clock); #1; end
        directed("restart", 0, 64'd50, 64'd5, 1'b0, 34, 64'd10, 64'd0, 1'b0, 33);

        startOp(0, 64'd12345, 64'd67, 1'b0);
        repeat (14) begin @(posedge clock); #1; end
        reset_n = 1'b0;
        #1;
        check("midReset.result", resOf(0), 64'd0);
        check("midReset.remainder", remOf(0), 64'd0);
        check("midReset.exception", 64'(excOf(0)), 64'd0);
        check("midReset.rdy", 64'(rdyOf(0)), 64'd0);
        check("midReset.busy", 64'(busyOf(0)), 64'd0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (40) begin @(posedge clock); #1; end

        directed("w8u200_13", 1, 64'd200, 64'd13, 1'b0, 10, 64'd15, 64'd5, 1'b0, 9);
        directed("w8sIgnored", 1, 64'hF0, 64'h02, 1'b1, 10, 64'h78, 64'd0, 1'b0, 9);

        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 80; k++) begin
                int n;
                int bc;
                startOp(d, pick(wOf(d)), pick(wOf(d)), 1'($urandom));
                if ($urandom_range(0, 3) == 0) begin
                    waitRdy(d, wOf(d) + 10, n, bc);
                end else begin
                    repeat ($urandom_range(0, wOf(d) + 3)) begin @(posedge clock); #1; end
                end
            end
            repeat (wOf(d) + 5) begin @(posedge clock); #1; end
        end

        repeat (5) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
